// File: rtl/clock_enable_divider_multi.sv
// N-channel clock-enable divider with staged, glitch-free divisor reloads and a common phase-align sync.
// Optional macro CLOCK_ENABLE_DIVIDER_TOGGLE_EN adds o_tgl_div, a per-channel square wave at 1/(2*D).
module clock_enable_divider_multi #(
  parameter int par_num_chan    = 4,
  parameter int par_div_width   = 16,
  parameter int par_ce_div_init = 1000,
  localparam int c_sel_width    = (par_num_chan > 1) ? $clog2(par_num_chan) : 1
) (
  input  logic                     i_clk_mhz,
  input  logic                     i_rst_mhz_n,
  input  logic                     i_ce_mhz,
  input  logic                     i_sync,
  input  logic                     i_load_valid,
  input  logic [c_sel_width-1:0]   i_load_chan,
  input  logic [par_div_width-1:0] i_load_div,
  output logic [par_num_chan-1:0]  o_ce_div,
  output logic [par_num_chan-1:0]  o_pending,
`ifdef CLOCK_ENABLE_DIVIDER_TOGGLE_EN
  output logic [par_num_chan-1:0]  o_tgl_div,
`endif
  output logic                     o_load_err
);

  localparam logic [par_div_width-1:0] c_div_init = par_div_width'(par_ce_div_init);
  localparam logic [c_sel_width:0]     c_num_chan = (c_sel_width + 1)'(par_num_chan);

  logic load_err_q, load_err_d;

  // Channel numbers are widened by one bit so non-power-of-two channel counts are range-checked too.
  always_comb begin
    load_err_d = i_load_valid && ({1'b0, i_load_chan} >= c_num_chan);
  end

  always_ff @(posedge i_clk_mhz or negedge i_rst_mhz_n) begin
    if (!i_rst_mhz_n) load_err_q <= 1'b0;
    else              load_err_q <= load_err_d;
  end

  assign o_load_err = load_err_q;

  for (genvar gi = 0; gi < par_num_chan; gi++) begin : g_chan
    logic [par_div_width-1:0] cnt_q, cnt_d;
    logic [par_div_width-1:0] act_q, act_d;
    logic [par_div_width-1:0] shd_q, shd_d;
    logic                     pend_q, pend_d;
    logic                     ce_q, ce_d;
    logic                     hit;
    logic                     wrap;

    always_comb begin
      hit    = i_load_valid && (i_load_chan == c_sel_width'(gi));
      wrap   = !i_sync && i_ce_mhz && (act_q != '0) && (cnt_q == act_q - 1'b1);
      cnt_d  = cnt_q;
      act_d  = act_q;
      shd_d  = hit ? i_load_div : shd_q;
      pend_d = pend_q | hit;
      ce_d   = 1'b0;
      if (i_sync) begin
        // A load landing on the sync cycle bypasses staging, same as at a wrap.
        cnt_d  = '0;
        act_d  = hit ? i_load_div : (pend_q ? shd_q : act_q);
        pend_d = 1'b0;
      end else if (act_q == '0) begin
        cnt_d = '0;
        if (pend_q) begin
          act_d  = shd_q;
          pend_d = hit;
        end
      end else if (i_ce_mhz) begin
        if (wrap) begin
          cnt_d  = '0;
          ce_d   = 1'b1;
          act_d  = hit ? i_load_div : (pend_q ? shd_q : act_q);
          pend_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge i_clk_mhz or negedge i_rst_mhz_n) begin
      if (!i_rst_mhz_n) begin
        cnt_q  <= '0;
        act_q  <= c_div_init;
        shd_q  <= c_div_init;
        pend_q <= 1'b0;
        ce_q   <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        shd_q  <= shd_d;
        pend_q <= pend_d;
        ce_q   <= ce_d;
      end
    end

    assign o_ce_div[gi]  = ce_q;
    assign o_pending[gi] = pend_q;

`ifdef CLOCK_ENABLE_DIVIDER_TOGGLE_EN
    logic tgl_q, tgl_d;

    always_comb begin
      tgl_d = i_sync ? 1'b0 : (wrap ? ~tgl_q : tgl_q);
    end

    always_ff @(posedge i_clk_mhz or negedge i_rst_mhz_n) begin
      if (!i_rst_mhz_n) tgl_q <= 1'b0;
      else              tgl_q <= tgl_d;
    end

    assign o_tgl_div[gi] = tgl_q;
`endif
  end

endmodule

// File: tb/tb_clock_enable_divider_multi.sv
// Scoreboard bench for clock_enable_divider_multi: directed scenarios followed by random stimulus,
// checked against an enables-remaining reference model.
module tb_clock_enable_divider_multi;
  localparam int NCH  = 5;
  localparam int W    = 8;
  localparam int INIT = 4;
  localparam int SELW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ce_r, sync_r, lv_r;
  logic [SELW-1:0] lc_r;
  logic [W-1:0]    ld_r;
  logic [NCH-1:0]  o_ce_div, o_pending;
  logic            o_load_err;
`ifdef CLOCK_ENABLE_DIVIDER_TOGGLE_EN
  logic [NCH-1:0]  o_tgl_div;
`endif

  always #5 clk = ~clk;

  clock_enable_divider_multi #(
    .par_num_chan(NCH), .par_div_width(W), .par_ce_div_init(INIT)
  ) dut (
    .i_clk_mhz(clk), .i_rst_mhz_n(rst_n), .i_ce_mhz(ce_r), .i_sync(sync_r),
    .i_load_valid(lv_r), .i_load_chan(lc_r), .i_load_div(ld_r),
    .o_ce_div(o_ce_div), .o_pending(o_pending),
`ifdef CLOCK_ENABLE_DIVIDER_TOGGLE_EN
    .o_tgl_div(o_tgl_div),
`endif
    .o_load_err(o_load_err)
  );

  typedef struct {
    logic [NCH-1:0] ce;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] tgl;
    logic           err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;

  // Reference model: remaining enables until the next pulse, plus active/shadow/pending per channel.
  int             m_act[NCH];
  int             m_shd[NCH];
  int             m_rem[NCH];
  bit             m_pend[NCH];
  bit             m_tgl[NCH];

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_act[k] = INIT; m_shd[k] = INIT; m_rem[k] = INIT; m_pend[k] = 0; m_tgl[k] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_step();
    exp_t e;
    bit   hit;
    e.ce = '0; e.pend = '0; e.tgl = '0;
    e.err = lv_r && (int'(lc_r) >= NCH);
    for (int k = 0; k < NCH; k++) begin
      hit = lv_r && (int'(lc_r) == k);
      if (sync_r) begin
        m_act[k]  = hit ? int'(ld_r) : (m_pend[k] ? m_shd[k] : m_act[k]);
        if (hit) m_shd[k] = int'(ld_r);
        m_pend[k] = 0;
        m_rem[k]  = m_act[k];
        m_tgl[k]  = 0;
      end else if (m_act[k] == 0) begin
        if (m_pend[k]) m_act[k] = m_shd[k];
        m_pend[k] = hit;
        if (hit) m_shd[k] = int'(ld_r);
        m_rem[k] = m_act[k];
      end else if (ce_r && m_rem[k] == 1) begin
        e.ce[k]   = 1'b1;
        m_tgl[k]  = !m_tgl[k];
        m_act[k]  = hit ? int'(ld_r) : (m_pend[k] ? m_shd[k] : m_act[k]);
        if (hit) m_shd[k] = int'(ld_r);
        m_pend[k] = 0;
        m_rem[k]  = m_act[k];
      end else begin
        if (ce_r) m_rem[k]--;
        if (hit) begin
          m_shd[k]  = int'(ld_r);
          m_pend[k] = 1;
        end
      end
      e.pend[k] = m_pend[k];
      e.tgl[k]  = m_tgl[k];
    end
    exp_q.push_back(e);
  endtask

  // Drive one clock's inputs, let the model follow the same edge, then move off the edge.
  task automatic step(input bit ce, input bit sy, input bit lv, input int lc, input int ld);
    ce_r = ce; sync_r = sy; lv_r = lv; lc_r = SELW'(lc); ld_r = W'(ld);
    @(posedge clk);
    cyc++;
    if (mon_en) model_step();
    #1;
  endtask

  task automatic idle(input int n, input bit ce);
    for (int i = 0; i < n; i++) step(ce, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      if (o_ce_div !== mon_e.ce || o_pending !== mon_e.pend || o_load_err !== mon_e.err) begin
        n_err++;
        $display("FAIL scoreboard cyc=%0d actual ce=%b pend=%b err=%b required ce=%b pend=%b err=%b",
                 cyc, o_ce_div, o_pending, o_load_err, mon_e.ce, mon_e.pend, mon_e.err);
      end
`ifdef CLOCK_ENABLE_DIVIDER_TOGGLE_EN
      n_cmp++;
      if (o_tgl_div !== mon_e.tgl) begin
        n_err++;
        $display("FAIL toggle cyc=%0d actual %b required %b", cyc, o_tgl_div, mon_e.tgl);
      end
`endif
    end
  end

  task automatic check_idle_outputs(input string name);
    n_cmp++;
    if (o_ce_div !== '0 || o_pending !== '0 || o_load_err !== 1'b0) begin
      n_err++;
      $display("FAIL %s actual ce=%b pend=%b err=%b required all zero", name, o_ce_div, o_pending, o_load_err);
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    ce_r = 0; sync_r = 0; lv_r = 0; lc_r = '0; ld_r = '0;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_async");
    @(posedge clk); @(posedge clk);
    #1;
    check_idle_outputs("reset_hold");
    model_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
  endtask

  initial begin
    int first;
    bit seen;
    do_reset();

    // Divisor 4 with enable every cycle: first pulse visible after the 4th clock.
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1, 0, 0, 0, 0);
      if (first == 0 && o_ce_div[0]) first = i;
    end
    n_cmp++;
    if (first != INIT) begin
      n_err++;
      $display("FAIL first_pulse actual clock %0d required clock %0d", first, INIT);
    end

    // Enable 1 in 3 with ch1 reloaded to 2.
    step(0, 1, 1, 1, 2);
    for (int i = 0; i < 24; i++) step(i % 3 == 0, 0, 0, 0, 0);

    // ch0 reloaded to 10 while cnt=1.
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 10);
    n_cmp++;
    if (o_pending[0] !== 1'b1) begin
      n_err++;
      $display("FAIL pending_after_load actual %b required 1", o_pending[0]);
    end
    idle(30, 1);

    // ch2 disabled, then re-enabled with 3.
    step(1, 0, 1, 2, 0);
    idle(10, 1);
    step(1, 0, 1, 2, 3);
    idle(10, 1);

    // ch3 loaded with 5 exactly on its wrap cycle (4th enable after sync).
    step(0, 1, 0, 0, 0);
    idle(3, 1);
    step(1, 0, 1, 3, 5);
    n_cmp++;
    if (o_pending[3] !== 1'b0) begin
      n_err++;
      $display("FAIL bypass_pending actual %b required 0", o_pending[3]);
    end
    idle(12, 1);

    // Out-of-range channel loads.
    step(0, 0, 1, 5, 7);
    step(0, 0, 1, 7, 1);
    idle(2, 0);

    // Divisors 4/8 phase-aligned by sync.
    step(1, 0, 1, 0, 4);
    step(1, 0, 1, 1, 8);
    step(1, 1, 0, 0, 0);
    idle(24, 1);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 11) == 0), $urandom_range(0, 7), $urandom_range(0, 12));
    end
    idle(3, 0);

    // Asynchronous reset while a pulse is on the output.
    seen = 0;
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1, 0, 0, 0, 0);
      if (o_ce_div != '0) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL pulse_before_reset actual none required a pulse within 40 clocks");
    end
    do_reset();
    idle(10, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
